// File: rtl/sync_input_pkg.sv
// Shared definitions for the sync_input_filter block.
//
// Contents:
//   FILTER_W_DEFAULT - default width of the stability counter / filter_len
//   EVT_CNT_W        - width of the optional flip event counter
//   filt_cnt_t       - stability counter type at the default width
//   evt_cnt_t        - event counter type
package sync_input_pkg;

  localparam int FILTER_W_DEFAULT = 4;
  localparam int EVT_CNT_W        = 8;

  typedef logic [FILTER_W_DEFAULT-1:0] filt_cnt_t;
  typedef logic [EVT_CNT_W-1:0]        evt_cnt_t;

endpackage

// File: rtl/sync_input_filter_if.sv
// Signal bundle between the filter block and its user (event/IRQ logic).
//
// Handshake: there is none. Every input is sampled on every rising clock
// edge and every output is valid in every cycle; no valid/ready pair exists.
//
// Signals:
//   in_sync         synchronized raw input
//   filter_len      mismatching samples needed to flip level (0 acts as 1)
//   rise_en/fall_en edge enables for pending
//   clear           one-cycle pulse clearing pending
//   level           filtered level
//   rise_pulse      one-cycle pulse on 0->1
//   fall_pulse      one-cycle pulse on 1->0
//   pending         sticky event flag
//   event_count_clr / event_count  only with SYNC_INPUT_FILTER_EVENT_COUNT_EN
//
// Modports: master drives the inputs of the block, slave is the block.
interface sync_input_filter_if
  import sync_input_pkg::*;
#(
  parameter int FILTER_W = FILTER_W_DEFAULT
) ();

  logic                in_sync;
  logic [FILTER_W-1:0] filter_len;
  logic                rise_en;
  logic                fall_en;
  logic                clear;
  logic                level;
  logic                rise_pulse;
  logic                fall_pulse;
  logic                pending;
`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
  logic                event_count_clr;
  evt_cnt_t            event_count;

  modport master (
    output in_sync, filter_len, rise_en, fall_en, clear, event_count_clr,
    input  level, rise_pulse, fall_pulse, pending, event_count
  );

  modport slave (
    input  in_sync, filter_len, rise_en, fall_en, clear, event_count_clr,
    output level, rise_pulse, fall_pulse, pending, event_count
  );
`else
  modport master (
    output in_sync, filter_len, rise_en, fall_en, clear,
    input  level, rise_pulse, fall_pulse, pending
  );

  modport slave (
    input  in_sync, filter_len, rise_en, fall_en, clear,
    output level, rise_pulse, fall_pulse, pending
  );
`endif

endinterface

// File: rtl/sync_input_edge_det.sv
// Registered edge detector for the filtered level.
//
// Looks at the current level and the value it will take on the next edge,
// so the pulses come out of flops in the same cycle the new level appears.
//
// Ports:
//   clock, reset      block clock, synchronous active-high reset
//   i_level_next      level value to be registered on this edge
//   i_level           current registered level
//   o_rise_pulse      high for one cycle after a 0->1 transition
//   o_fall_pulse      high for one cycle after a 1->0 transition
module sync_input_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic i_level_next,
  input  logic i_level,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  logic r_rise_pulse;
  logic r_fall_pulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_rise_pulse <= i_level_next & ~i_level;
      r_fall_pulse <= ~i_level_next & i_level;
    end
  end

  assign o_rise_pulse = r_rise_pulse;
  assign o_fall_pulse = r_fall_pulse;

endmodule

// File: rtl/sync_input_filter.sv
// Glitch filter, edge detector and sticky pending flag for one synchronized
// GPIO / external-interrupt input.
//
// The level only flips after filter_len consecutive samples disagree with
// it; any agreeing sample restarts the count. Edges of the filtered level
// produce one-cycle pulses and, when enabled, set pending until cleared.
//
// Optional feature (macro SYNC_INPUT_FILTER_EVENT_COUNT_EN): a saturating
// 8-bit count of level flips with its own clear input.
//
// Ports:
//   clock  block clock (same domain as the synchronizer output)
//   reset  synchronous active-high reset
//   bus    sync_input_filter_if.slave, see the interface for signal list
module sync_input_filter
  import sync_input_pkg::*;
#(
  parameter int FILTER_W    = FILTER_W_DEFAULT,
  parameter bit RESET_LEVEL = 1'b0
) (
  input logic                  clock,
  input logic                  reset,
  sync_input_filter_if.slave   bus
);

  logic [FILTER_W-1:0] r_cnt;
  logic                r_level;
  logic                r_pending;

  logic [FILTER_W-1:0] w_eff_len;
  logic [FILTER_W:0]   w_cnt_inc;
  logic                w_mismatch;
  logic                w_flip;
  logic                w_level_next;
  logic                w_set_pending;
  logic                w_rise_pulse;
  logic                w_fall_pulse;

  // filter_len of 0 behaves as 1 (plain one-cycle delay).
  assign w_eff_len = (bus.filter_len == '0) ? {{(FILTER_W-1){1'b0}}, 1'b1}
                                            : bus.filter_len;

  // One extra bit so cnt+1 cannot wrap back below eff_len.
  assign w_cnt_inc  = {1'b0, r_cnt} + {{FILTER_W{1'b0}}, 1'b1};
  assign w_mismatch = (bus.in_sync != r_level);
  assign w_flip     = w_mismatch && (w_cnt_inc >= {1'b0, w_eff_len});

  assign w_level_next = w_flip ? bus.in_sync : r_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
    end else if (!w_mismatch) begin
      r_cnt   <= '0;
    end else if (w_flip) begin
      r_level <= bus.in_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= w_cnt_inc[FILTER_W-1:0];
    end
  end

  // Enables are only looked at on the flip edge itself.
  assign w_set_pending = w_flip &&
                         ((bus.in_sync && bus.rise_en) ||
                          (!bus.in_sync && bus.fall_en));

  // Set has priority over clear on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_set_pending) begin
      r_pending <= 1'b1;
    end else if (bus.clear) begin
      r_pending <= 1'b0;
    end
  end

  sync_input_edge_det u_edge_det (
    .clock        (clock),
    .reset        (reset),
    .i_level_next (w_level_next),
    .i_level      (r_level),
    .o_rise_pulse (w_rise_pulse),
    .o_fall_pulse (w_fall_pulse)
  );

  assign bus.level      = r_level;
  assign bus.rise_pulse = w_rise_pulse;
  assign bus.fall_pulse = w_fall_pulse;
  assign bus.pending    = r_pending;

`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
  evt_cnt_t r_event_count;

  // A flip on the clearing edge counts as the first event after the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_event_count <= '0;
    end else if (w_flip) begin
      if (bus.event_count_clr) begin
        r_event_count <= {{(EVT_CNT_W-1){1'b0}}, 1'b1};
      end else if (r_event_count != {EVT_CNT_W{1'b1}}) begin
        r_event_count <= r_event_count + {{(EVT_CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (bus.event_count_clr) begin
      r_event_count <= '0;
    end
  end

  assign bus.event_count = r_event_count;
`endif

endmodule

// File: tb/tb_sync_input_filter.sv
// Directed bench for sync_input_filter. A sample-history model predicts the
// outputs; every cycle all outputs are compared against it, and literal
// expectations at the key points of each scenario pin the model itself.
module tb_sync_input_filter;

  localparam int FW = 4;

  logic clock;
  logic reset;

  int n_vec;
  int n_err;

  sync_input_filter_if #(.FILTER_W(FW)) bus ();

  sync_input_filter #(
    .FILTER_W    (FW),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  // Keeps the raw samples seen since the last flip/reset and decides a flip
  // when the most recent eff_len samples all disagree with the level.
  bit m_hist[$];
  bit m_level;
  bit m_rise;
  bit m_fall;
  bit m_pending;
  int m_ev;

  function automatic int trailing_disagree(bit lvl);
    int n;
    n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] == lvl) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_update();
    int  eff;
    bit  flip;
    bit  ev_clr;
    ev_clr = 1'b0;
`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
    ev_clr = bus.event_count_clr;
`endif
    if (reset) begin
      m_hist.delete();
      m_level   = 1'b0;
      m_rise    = 1'b0;
      m_fall    = 1'b0;
      m_pending = 1'b0;
      m_ev      = 0;
    end else begin
      m_hist.push_back(bus.in_sync);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      eff  = (bus.filter_len == 0) ? 1 : int'(bus.filter_len);
      flip = (trailing_disagree(m_level) >= eff);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (flip) begin
        m_level = bus.in_sync;
        m_hist.delete();
        m_rise = m_level;
        m_fall = !m_level;
        if ((m_level && bus.rise_en) || (!m_level && bus.fall_en))
          m_pending = 1'b1;
        else if (bus.clear)
          m_pending = 1'b0;
        if (ev_clr) m_ev = 1;
        else if (m_ev < 255) m_ev = m_ev + 1;
      end else begin
        if (bus.clear) m_pending = 1'b0;
        if (ev_clr) m_ev = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("level",      int'(bus.level),      int'(m_level));
    chk("rise_pulse", int'(bus.rise_pulse), int'(m_rise));
    chk("fall_pulse", int'(bus.fall_pulse), int'(m_fall));
    chk("pending",    int'(bus.pending),    int'(m_pending));
`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
    chk("event_count", int'(bus.event_count), m_ev);
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic steps(int n, bit v);
    for (int i = 0; i < n; i++) begin
      bus.in_sync = v;
      step();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    reset          = 1'b1;
    bus.in_sync    = 1'b0;
    bus.filter_len = '0;
    bus.rise_en    = 1'b0;
    bus.fall_en    = 1'b0;
    bus.clear      = 1'b0;
`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
    bus.event_count_clr = 1'b0;
`endif
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_pending = 1'b0; m_ev = 0;

    step();
    step();
    chk("reset_level",   int'(bus.level), 0);
    chk("reset_pending", int'(bus.pending), 0);
    chk("reset_rise",    int'(bus.rise_pulse), 0);
    reset = 1'b0;

    // Glitch rejection: 2-sample pulse with filter_len=3.
    bus.filter_len = 4'd3;
    steps(2, 1'b1);
    steps(1, 1'b0);
    chk("glitch_level",   int'(bus.level), 0);
    chk("glitch_pending", int'(bus.pending), 0);

    // Rise after 3 samples, pulse for exactly one cycle, pending sticky.
    bus.rise_en = 1'b1;
    steps(2, 1'b1);
    chk("rise_wait_level", int'(bus.level), 0);
    steps(1, 1'b1);
    chk("rise_level", int'(bus.level), 1);
    chk("rise_pulse_on", int'(bus.rise_pulse), 1);
    steps(1, 1'b1);
    chk("rise_pulse_off", int'(bus.rise_pulse), 0);
    chk("rise_pending", int'(bus.pending), 1);
    bus.clear = 1'b1;
    steps(1, 1'b1);
    bus.clear = 1'b0;
    chk("clear_pending", int'(bus.pending), 0);

    // Bypass: filter_len=0 behaves as one-cycle delay.
    bus.rise_en    = 1'b0;
    bus.filter_len = 4'd0;
    steps(2, 1'b0);
    chk("bypass_low", int'(bus.level), 0);
    steps(1, 1'b1);
    chk("bypass_rise", int'(bus.rise_pulse), 1);
    steps(1, 1'b0);
    chk("bypass_fall", int'(bus.fall_pulse), 1);
    chk("bypass_level", int'(bus.level), 0);

    // Collision: set and clear on the same flip edge.
    bus.filter_len = 4'd1;
    steps(1, 1'b1);
    bus.fall_en = 1'b1;
    bus.clear   = 1'b1;
    steps(1, 1'b0);
    chk("collide_pending", int'(bus.pending), 1);
    steps(1, 1'b0);
    bus.clear   = 1'b0;
    chk("collide_clear", int'(bus.pending), 0);
    bus.fall_en = 1'b0;

    // Reset mid-count discards the partial count.
    bus.filter_len = 4'd15;
    steps(10, 1'b1);
    reset = 1'b1;
    steps(1, 1'b1);
    reset = 1'b0;
    steps(14, 1'b1);
    chk("rst_mid_no_flip", int'(bus.level), 0);
    steps(1, 1'b1);
    chk("rst_mid_flip", int'(bus.level), 1);

    // Maximum filter length.
    steps(14, 1'b0);
    chk("max_no_flip", int'(bus.level), 1);
    steps(1, 1'b0);
    chk("max_flip", int'(bus.level), 0);
    chk("max_fall", int'(bus.fall_pulse), 1);

    // Lowering filter_len mid-count takes effect on the next mismatch.
    bus.filter_len = 4'd5;
    steps(3, 1'b1);
    chk("lower_wait", int'(bus.level), 0);
    bus.filter_len = 4'd2;
    steps(1, 1'b1);
    chk("lower_flip", int'(bus.level), 1);

    // Pseudo-random mix of inputs, lengths, enables and clears.
    for (int i = 0; i < 200; i++) begin
      bus.filter_len = 4'($urandom_range(0, 3));
      bus.rise_en    = 1'($urandom_range(0, 1));
      bus.fall_en    = 1'($urandom_range(0, 1));
      bus.clear      = ($urandom_range(0, 7) == 0);
      bus.in_sync    = 1'($urandom_range(0, 1));
      step();
    end
    bus.clear = 1'b0;

`ifdef SYNC_INPUT_FILTER_EVENT_COUNT_EN
    // Event counter clear, saturation, and clear-with-flip.
    bus.filter_len = 4'd0;
    bus.event_count_clr = 1'b1;
    steps(1, bus.level);
    bus.event_count_clr = 1'b0;
    chk("evt_cleared", int'(bus.event_count), 0);
    for (int i = 0; i < 300; i++) steps(1, !bus.level);
    chk("evt_saturate", int'(bus.event_count), 255);
    bus.event_count_clr = 1'b1;
    steps(1, !bus.level);
    bus.event_count_clr = 1'b0;
    chk("evt_clr_flip", int'(bus.event_count), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
